// File: rtl/jtlb_arb.sv
// Arbiter/sequencer for the shared joint TLB: grants micro-ITLB, micro-DTLB
// and CP0 TLB-op requests one at a time and registers the JTLB results.
module jtlb_arb #(
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        phi2,
  input  logic        ireq,
  input  logic [63:0] iva,
  output logic        idone,
  input  logic        dreq,
  input  logic [63:0] dva,
  input  logic        dwr,
  output logic        ddone,
  input  logic        opreq,
  input  logic [1:0]  op,
  output logic        opdone,
  output logic [31:0] res_pa,
  output logic        res_cache,
  output logic        res_miss,
  output logic        res_inval,
  output logic        res_mod,
  output logic        res_ade,
  output logic [63:0] jtlbva,
  output logic        jtlbreq,
  output logic        jtlbwr,
  output logic        tlbr,
  output logic        tlbwi,
  output logic        tlbwr,
  output logic        tlbp,
  input  logic [31:0] jtlbpa,
  input  logic        jtlbcache,
  input  logic        jtlbmiss,
  input  logic        jtlbade,
  input  logic        jtlbinval,
  input  logic        jtlbmod,
  input  logic        jtlbshut,
  output logic        shut,
  output logic        busy
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE);

  typedef enum logic [1:0] {IDLE, LOOK, OP, DONE} state_t;
  typedef enum logic [1:0] {W_I, W_D, W_OP} win_t;

  state_t        state;
  win_t          win;
  logic [CW-1:0] cnt;

  logic gnt_op, gnt_d, gnt_i, win_req;

  // Ops first, then D unless I has waited through STARVE consecutive D grants.
  always_comb begin
    gnt_op  = opreq;
    gnt_d   = !opreq && dreq && !(ireq && cnt == CNT_MAX);
    gnt_i   = !opreq && !gnt_d && ireq;
    win_req = (win == W_I) ? ireq : dreq;
  end

  assign busy = (state != IDLE);

  // NOTE: every register here is updated with non-blocking assignments so all
  // state moves together on the step edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      win       <= W_I;
      cnt       <= '0;
      idone     <= 1'b0;
      ddone     <= 1'b0;
      opdone    <= 1'b0;
      res_pa    <= '0;
      res_cache <= 1'b0;
      res_miss  <= 1'b0;
      res_inval <= 1'b0;
      res_mod   <= 1'b0;
      res_ade   <= 1'b0;
      jtlbva    <= '0;
      jtlbreq   <= 1'b0;
      jtlbwr    <= 1'b0;
      tlbr      <= 1'b0;
      tlbwi     <= 1'b0;
      tlbwr     <= 1'b0;
      tlbp      <= 1'b0;
      shut      <= 1'b0;
    end else if (phi2) begin
      if (!ireq) cnt <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_op) begin
            win   <= W_OP;
            state <= OP;
            tlbr  <= (op == 2'b00);
            tlbwi <= (op == 2'b01);
            tlbwr <= (op == 2'b10);
            tlbp  <= (op == 2'b11);
          end else if (gnt_d || gnt_i) begin
            win <= gnt_d ? W_D : W_I;
            if (gnt_i) cnt <= '0;
            else if (ireq && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (shut) begin
              // Shut-down TLB: report a miss without touching the JTLB.
              state     <= DONE;
              idone     <= gnt_i;
              ddone     <= gnt_d;
              res_pa    <= '0;
              res_cache <= 1'b0;
              res_miss  <= 1'b1;
              res_inval <= 1'b0;
              res_mod   <= 1'b0;
              res_ade   <= 1'b0;
            end else begin
              state   <= LOOK;
              jtlbreq <= 1'b1;
              jtlbva  <= gnt_d ? dva : iva;
              jtlbwr  <= gnt_d && dwr;
            end
          end
        end
        LOOK: begin
          jtlbreq <= 1'b0;
          jtlbva  <= '0;
          jtlbwr  <= 1'b0;
          if (win_req) begin
            state     <= DONE;
            idone     <= (win == W_I);
            ddone     <= (win == W_D);
            res_pa    <= jtlbpa;
            res_cache <= jtlbcache;
            res_miss  <= jtlbmiss;
            res_inval <= jtlbinval;
            res_mod   <= jtlbmod;
            res_ade   <= jtlbade;
            shut      <= shut | jtlbshut;
          end else begin
            state <= IDLE;
          end
        end
        OP: begin
          tlbr   <= 1'b0;
          tlbwi  <= 1'b0;
          tlbwr  <= 1'b0;
          tlbp   <= 1'b0;
          opdone <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          idone  <= 1'b0;
          ddone  <= 1'b0;
          opdone <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jtlb_arb.md
Name: jtlb_arb

Overview:
- Arbiter and sequencer for the shared joint TLB. It accepts micro-ITLB refill lookups, micro-DTLB refill lookups and CP0 TLB instructions (TLBR/TLBWI/TLBWR/TLBP).
- It grants one requester at a time, drives the JTLB lookup/strobe inputs, and captures the JTLB's combinational results into a registered result bus.
- It keeps a sticky TLB-shutdown flag and sits between the pipeline's micro-TLBs/CP0 and the jtlb block.

Parameters:
- STARVE, 4: maximum consecutive D grants while ireq is pending; after that, I is forced to win.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous reset, active low
- phi2  in  1  phase enable; all state changes happen only on clk edges with phi2=1 (a "step")
- ireq  in  1  instruction refill request, held until idone
- iva  in  64  instruction virtual address
- idone  out  1  instruction result valid
- dreq  in  1  data refill request, held until ddone
- dva  in  64  data virtual address
- dwr  in  1  data access is a store
- ddone  out  1  data result valid
- opreq  in  1  CP0 TLB-instruction request, held until opdone
- op  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
- opdone  out  1  CP0 op complete
- res_pa  out  32  captured physical address
- res_cache, res_miss, res_inval, res_mod, res_ade  out  1 each  captured result flags
- jtlbva  out  64  lookup VA to JTLB
- jtlbreq  out  1  lookup enable to JTLB
- jtlbwr  out  1  lookup is a store
- tlbr, tlbwi, tlbwr, tlbp  out  1 each  CP0 op strobes to JTLB
- jtlbpa  in  32  JTLB PA
- jtlbcache, jtlbmiss, jtlbade, jtlbinval, jtlbmod  in  1 each  JTLB result flags
- jtlbshut  in  1  JTLB multiple-match indication
- shut  out  1  sticky TLB shutdown
- busy  out  1  state != IDLE

Behaviour:
- **Reset:** rstn=0 at a clk edge forces the following, regardless of phi2:
  - state IDLE; all outputs 0; res_* 0; starvation counter 0; shut 0.
  - Reset mid-lookup or mid-op abandons it with no done pulse.
- **States:** IDLE, LOOK, OP, DONE. Transitions happen only on steps.
- **IDLE, arbitration priority:**
  - opreq wins first.
  - Then dreq, unless ireq is pending and the counter == STARVE, in which case ireq wins.
  - Otherwise ireq.
- **IDLE, on grant:**
  - Latch the winner id, VA, dwr and op.
  - An I/D grant goes to LOOK, or to DONE directly if shut=1.
  - An op grant goes to OP.
- **Starvation counter:**
  - D grant while ireq=1: counter+1, saturating at STARVE.
  - I grant, or ireq=0 at a step: counter cleared.
- **LOOK:**
  - Drive jtlbreq=1, jtlbva=latched VA, jtlbwr=latched dwr (dwr forced 0 for I).
  - At the next step, if the winner's req is still high: capture jtlbpa/flags into res_*, set shut if jtlbshut=1, go DONE.
  - If the winner's req dropped (squash): go IDLE; res_* unchanged; no done.
- **OP:**
  - Exactly one of tlbr/tlbwi/tlbwr/tlbp is high for exactly one step period per op[1:0]; never high outside OP.
  - At the next step, go DONE.
  - Ops are not cancellable; opreq dropping in OP is ignored.
- **shut=1 bypass:**
  - I/D requests skip LOOK with res_miss=1, res_pa=0, other flags 0; jtlbreq is not asserted.
  - CP0 ops still execute.
  - shut clears only on reset.
- **DONE:**
  - Exactly one of idone/ddone/opdone (matching the latched winner) is high for the whole step period.
  - At the next step, go IDLE.
  - Requesters drop req during DONE. A req still high at the next IDLE step is treated as a new request.
- **Hold rules:**
  - jtlbreq, jtlbva and jtlbwr are held stable for the full LOOK period.
  - jtlbva is 0 and jtlbreq is 0 outside LOOK.
  - res_* hold until the next capture.
- **Latency (no contention, step-counted from the step sampling req in IDLE):**
  - Lookup: done high after step 2, for one step period.
  - Op: strobe during step period 1, done after step 2.
  - Shut bypass: done after step 1.
- **Simultaneous events:**
  - opreq+dreq+ireq together: op, then D, then I, with counter rules applied.
  - jtlbshut and jtlbmiss together at capture: both recorded; res_miss=1, shut=1.

Test Plan:
- ireq=1, iva=0x0000_0000_0040_1000, JTLB returns pa=0x0010_1000, cache=1 -> jtlbreq high one step with jtlbva=iva and jtlbwr=0; idone one step later with res_pa=0x0010_1000, res_cache=1.
- dreq and ireq held continuously, STARVE=4 -> grant order D,D,D,D,I,D,D,D,D,I; counter clears after each I grant.
- opreq with op=10 concurrent with dreq -> tlbwr high exactly one step period, opdone next; then the D lookup runs; tlbr/tlbwi/tlbp never pulse.
- dreq dropped during LOOK -> returns to IDLE with no ddone; res_* keep their previous value.
- jtlbshut=1 with jtlbmiss=1 at capture -> shut=1, res_miss=1; a subsequent ireq gives idone after one step with res_miss=1 and no jtlbreq; rstn low for one clk -> shut=0, busy=0.
- phi2 held 0 for 5 clks mid-LOOK -> state, jtlbreq and jtlbva are frozen; capture occurs only at the next phi2 edge.
